// File: rtl/iter_multiplier_if.sv
// Request/response handshake bundle for the iterative multiplier.
// The master issues operands; the slave returns the product.
interface iter_multiplier_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Works on operand magnitudes, fixes the sign once at the end.
module iter_multiplier #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2,
  parameter bit EARLY_OUT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  output logic busy,
  iter_multiplier_if.slave bus
);

  localparam int W = 2 * XLEN;
  localparam int STEPS =
    (RADIX_BITS > 0) ? XLEN / RADIX_BITS : 1;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [XLEN:0] ONE_X = 1;
  localparam logic [W-1:0]  ONE_W = 1;

  if (RADIX_BITS < 1 || RADIX_BITS > XLEN ||
      ((RADIX_BITS >= 1) ?
       (XLEN % RADIX_BITS) != 0 : 1'b1))
  begin : g_bad_radix
    $error("RADIX_BITS must divide XLEN");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [XLEN:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            a_signed;
  logic            b_signed;
  logic [XLEN:0]   a_ext;
  logic [XLEN:0]   b_ext;
  logic [XLEN:0]   a_mag;
  logic [XLEN:0]   b_mag;
  logic            accept;
  logic [W-1:0]    digit_w;
  logic [W-1:0]    partial;
  logic [XLEN:0]   b_nxt;
  logic            last_step;
  logic [W-1:0]    prod;

  // Operand signedness per funct3
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (bus.req_op)
      2'b00: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      2'b01: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      2'b10: begin
        a_signed = 1'b1;
      end
      2'b11: begin
      end
      default: begin
      end
    endcase
  end

  // One extra bit keeps |most-negative| exact
  assign a_ext = {a_signed & bus.req_a[XLEN-1], bus.req_a};
  assign b_ext = {b_signed & bus.req_b[XLEN-1], bus.req_b};
  assign a_mag = a_ext[XLEN] ? (~a_ext + ONE_X) : a_ext;
  assign b_mag = b_ext[XLEN] ? (~b_ext + ONE_X) : b_ext;

  assign accept  = bus.req_valid && bus.req_ready;
  assign digit_w = W'(b_sh_q[RADIX_BITS-1:0]);
  assign partial = digit_w * a_sh_q;
  assign b_nxt   = b_sh_q >> RADIX_BITS;

  assign last_step = (cnt_q == CW'(1)) ||
                     (EARLY_OUT && (b_nxt == '0));

  assign prod = neg_q ? (~acc_q + ONE_W) : acc_q;

  assign bus.req_ready  = (state_q == S_IDLE) && !flush;
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_data  = res_q;
  assign busy           = (state_q != S_IDLE);

  // Next state and datapath updates
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    op_d    = op_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_sh_d  = {{(XLEN-1){1'b0}}, a_mag};
          b_sh_d  = b_mag;
          neg_d   = a_ext[XLEN] ^ b_ext[XLEN];
          op_d    = bus.req_op;
          acc_d   = '0;
          cnt_d   = CW'(STEPS);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d  = acc_q + partial;
        a_sh_d = a_sh_q << RADIX_BITS;
        b_sh_d = b_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (last_step) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d = (op_q == 2'b00) ?
                prod[XLEN-1:0] : prod[W-1:XLEN];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      op_q    <= 2'b00;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// Bench for iter_multiplier across several radix/early-out setups.
// Results and latencies come from an arithmetic reference model.
module tb_iter_multiplier;

  localparam int ND = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  int          sel = 0;

  logic [ND-1:0] rv;
  logic [ND-1:0] rr;
  logic [ND-1:0] bsy;
  logic [31:0]   rd [ND];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  function automatic int rad_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 4;
      3: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic bit eo_of(input int k);
    return (k == 1) || (k == 2);
  endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    iter_multiplier_if #(.XLEN(32)) bus ();
    iter_multiplier #(
      .XLEN(32),
      .RADIX_BITS(rad_of(gi)),
      .EARLY_OUT(eo_of(gi))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .busy(bsy[gi]),
      .bus(bus.slave)
    );
    assign bus.req_valid  = req_valid && (sel == gi);
    assign bus.req_op     = req_op;
    assign bus.req_a      = req_a;
    assign bus.req_b      = req_b;
    assign bus.resp_ready = resp_ready && (sel == gi);
    assign rv[gi] = bus.resp_valid;
    assign rr[gi] = bus.req_ready;
    assign rd[gi] = bus.resp_data;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full 64-bit product of the operands as RV32M defines them
  function automatic logic [31:0] model_res(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from the accept edge to resp_valid
  function automatic int model_lat(input int k,
                                   input logic [1:0] op,
                                   input logic [31:0] b);
    int r, bl, n;
    logic [32:0] m;
    r = rad_of(k);
    if (!eo_of(k)) return 32 / r + 1;
    m = {1'b0, b};
    if (op[1] == 1'b0 && b[31])
      m = 33'h1_0000_0000 - {1'b0, b};
    bl = 0;
    for (int i = 0; i < 33; i++)
      if (m[i]) bl = i + 1;
    n = (bl + r - 1) / r;
    if (n < 1) n = 1;
    return n + 1;
  endfunction

  task automatic issue(input int k, input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    sel = k;
    @(negedge clk);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int k, output int cyc);
    cyc = 0;
    while (!rv[k] && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_op(input int k, input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag);
    int cyc;
    issue(k, op, a, b);
    wait_resp(k, cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(model_lat(k, op, b)));
    chk({tag, "_data"}, 64'(rd[k]), 64'(model_res(op, a, b)));
    release_resp();
    chk({tag, "_drop"}, 64'(rv[k]), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom & 32'hF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(rv[0]), 64'(0));
    chk("rst_data", 64'(rd[0]), 64'(0));
    chk("rst_busy", 64'(bsy), 64'(0));
    chk("rst_ready", 64'(rr), 64'({ND{1'b1}}));

    run_op(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
    run_op(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");
    run_op(0, 2'b01, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "mul_min");
    run_op(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");

    // Backpressure in DONE
    issue(0, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_resp(0, cyc);
    chk("bp_lat", 64'(cyc), 64'(17));
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(rv[0]), 64'(1));
      chk("bp_data", 64'(rd[0]),
          64'(model_res(2'b01, 32'h1234_5678, 32'h9ABC_DEF0)));
      chk("bp_ready", 64'(rr[0]), 64'(0));
    end
    release_resp();
    chk("bp_drop", 64'(rv[0]), 64'(0));
    chk("bp_reready", 64'(rr[0]), 64'(1));

    // Flush in IDLE overrides a request
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = 2'b00;
    req_a = 32'd5;
    req_b = 32'd5;
    #1;
    chk("fl_idle_rdy", 64'(rr[0]), 64'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_idle_busy", 64'(bsy[0]), 64'(0));

    // Flush in CALC cycle 3 with a request pending
    issue(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1;
    req_a = 32'd5;
    req_b = 32'd5;
    #1;
    chk("fl_calc_rdy", 64'(rr[0]), 64'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_calc_busy", 64'(bsy[0]), 64'(0));
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rv[0]) seen++;
    end
    chk("fl_noresp", 64'(seen), 64'(0));
    run_op(0, 2'b00, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    chk("mul_7x-3_lit", 64'(model_res(2'b00, 32'd7,
        32'hFFFF_FFFD)), 64'(rd[0] | 32'hFFFF_FFEB));

    // Early-out, radix 4
    run_op(2, 2'b11, 32'h1234_5678, 32'h5, "eo_r4");

    // Reset pulse while holding a result
    issue(0, 2'b00, 32'd100, 32'd200);
    wait_resp(0, cyc);
    chk("rd_pre", 64'(rv[0]), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rd_valid", 64'(rv[0]), 64'(0));
    chk("rd_data", 64'(rd[0]), 64'(0));
    chk("rd_ready", 64'(rr[0]), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rd_ready2", 64'(rr[0]), 64'(1));
    chk("rd_busy", 64'(bsy[0]), 64'(0));

    // Random sweep over every configuration
    for (int k = 0; k < ND; k++) begin
      int nops;
      nops = (k == 0) ? 300 : 150;
      for (int i = 0; i < nops; i++) begin
        logic [1:0] op;
        logic [31:0] a, b;
        op = 2'($urandom_range(0, 3));
        a = pick();
        b = pick();
        run_op(k, op, a, b, $sformatf("rnd_k%0d", k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
